multi_line_shift_buffer: RTL

- Parametrised successor of the single-line shift RAM.
- Holds NUM_LINES complete image lines in cascaded line RAMs, with the line length set at run time per frame.
- Each accepted pixel produces a vertical column of NUM_LINES+1 aligned taps (current row plus previous rows, same column).
- Sits between the pixel source and window/convolution stages (e.g. 3x3 filters with NUM_LINES=2).

---
 rtl/mlsb_pkg.sv | 17 +
 rtl/line_ram_sdp.sv | 38 +++
 rtl/multi_line_shift_buffer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mlsb_pkg.sv
// Shared types and constants for the multi-line shift buffer.
// Imported by the top level and its line RAM.
package mlsb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Default pixel width; each tap in the output column is this wide.
  localparam int TAP_W = 8;

  // Wide enough to count up to the largest supported NUM_LINES (8).
  localparam int LINE_CNT_W = 4;

endpackage

// File: rtl/line_ram_sdp.sv
// Simple dual-port line memory: synchronous read, read-before-write.
// Only the read data register is reset; the array keeps its contents.
module line_ram_sdp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wrEn_i,
  input  logic [ADDR_WIDTH-1:0] wrAddr_i,
  input  logic [DATA_WIDTH-1:0] wrData_i,
  input  logic                  rdEn_i,
  input  logic [ADDR_WIDTH-1:0] rdAddr_i,
  output logic [DATA_WIDTH-1:0] rdData_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdData_q;

  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  // Read data holds while rdEn_i is low so downstream taps stay stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdData_q <= '0;
    end else if (rdEn_i) begin
      rdData_q <= mem_q[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/multi_line_shift_buffer.sv
// Cascaded line buffer producing a vertical column of NUM_LINES+1 taps per
// accepted pixel; the line length is programmed per frame on I_Sof.
module multi_line_shift_buffer
  import mlsb_pkg::*;
#(
  parameter int DATA_WIDTH   = TAP_W,
  parameter int ADDR_WIDTH   = 11,
  parameter int MAX_LINE_LEN = 2048,
  parameter int NUM_LINES    = 2
) (
  input  logic                                I_CLK,
  input  logic                                I_Rst,
  input  logic                                I_Sof,
  input  logic [ADDR_WIDTH:0]                 I_Line_Len,
  input  logic                                I_Valid,
  input  logic [DATA_WIDTH-1:0]               I_Data,
  output logic                                O_Valid,
  output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] O_Taps,
  output logic [ADDR_WIDTH-1:0]               O_Col,
  output logic                                O_Eol,
  output logic                                O_Err
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0]      MAX_LEN    = LEN_W'(MAX_LINE_LEN);
  localparam logic [LINE_CNT_W-1:0] FULL_LINES = LINE_CNT_W'(NUM_LINES);

  state_e                  state_q, state_d, stateEff;
  logic [LEN_W-1:0]        len_q, len_d, lenEff;
  logic [ADDR_WIDTH-1:0]   col_q, col_d, colEff;
  logic [LINE_CNT_W-1:0]   line_q, line_d, lineEff;
  logic                    err_q, err_d;
  logic                    lenLegal, accept, lastCol;

  logic                    valid_q, eol_q, wrEn_q, fwdHit_q;
  logic [ADDR_WIDTH-1:0]   outCol_q;
  logic [DATA_WIDTH-1:0]   pix_q;
  logic [DATA_WIDTH-1:0]   fwd_q [1:NUM_LINES];
  logic [DATA_WIDTH-1:0]   ramRd [NUM_LINES];
  logic [DATA_WIDTH-1:0]   tap   [NUM_LINES+1];

  // I_Sof overrides the stored frame context in the same cycle, so a pixel
  // arriving with it is already column 0 of the new frame.
  always_comb begin
    lenLegal = (I_Line_Len != '0) && (I_Line_Len <= MAX_LEN);
    stateEff = I_Sof ? FILL : state_q;
    lenEff   = I_Sof ? (lenLegal ? I_Line_Len : MAX_LEN) : len_q;
    colEff   = I_Sof ? '0 : col_q;
    lineEff  = I_Sof ? '0 : line_q;
    accept   = I_Valid && (stateEff != IDLE);
    lastCol  = ({1'b0, colEff} == (lenEff - 1'b1));

    state_d = stateEff;
    len_d   = lenEff;
    col_d   = colEff;
    line_d  = lineEff;
    err_d   = I_Sof ? !lenLegal : err_q;

    if (accept) begin
      if (lastCol) begin
        col_d = '0;
        if (lineEff < FULL_LINES) begin
          line_d = lineEff + 1'b1;
        end
      end else begin
        col_d = colEff + 1'b1;
      end
    end

    if ((stateEff == FILL) && accept && lastCol && (line_d == FULL_LINES)) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_Rst) begin
      state_q <= IDLE;
      len_q   <= MAX_LEN;
      col_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      col_q   <= col_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  // RAM writes trail the read by one cycle; with a one-pixel line the next
  // read hits the pending write address, so its data is forwarded instead.
  always_ff @(posedge I_CLK) begin
    if (I_Rst) begin
      valid_q  <= 1'b0;
      eol_q    <= 1'b0;
      wrEn_q   <= 1'b0;
      fwdHit_q <= 1'b0;
      outCol_q <= '0;
      pix_q    <= '0;
      for (int k = 1; k <= NUM_LINES; k++) begin
        fwd_q[k] <= '0;
      end
    end else begin
      valid_q <= accept && (stateEff == RUN);
      wrEn_q  <= accept;
      if (accept) begin
        pix_q    <= I_Data;
        outCol_q <= colEff;
        eol_q    <= lastCol;
        fwdHit_q <= wrEn_q && (outCol_q == colEff);
        for (int k = 1; k <= NUM_LINES; k++) begin
          fwd_q[k] <= tap[k-1];
        end
      end
    end
  end

  always_comb begin
    tap[0] = pix_q;
    for (int k = 1; k <= NUM_LINES; k++) begin
      tap[k] = fwdHit_q ? fwd_q[k] : ramRd[k-1];
    end
  end

  // Line RAM k stores tap k, so each write shifts the column down one row.
  for (genvar k = 0; k < NUM_LINES; k++) begin : gLine
    line_ram_sdp #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (MAX_LINE_LEN)
    ) uRam (
      .clk_i    (I_CLK),
      .rst_i    (I_Rst),
      .wrEn_i   (wrEn_q),
      .wrAddr_i (outCol_q),
      .wrData_i (tap[k]),
      .rdEn_i   (accept),
      .rdAddr_i (colEff),
      .rdData_o (ramRd[k])
    );
  end

  always_comb begin
    O_Taps = '0;
    for (int k = 0; k <= NUM_LINES; k++) begin
      O_Taps[k*DATA_WIDTH +: DATA_WIDTH] = tap[k];
    end
  end

  assign O_Valid = valid_q;
  assign O_Col   = outCol_q;
  assign O_Eol   = eol_q;
  assign O_Err   = err_q;

endmodule
